// File: rtl/vram_scanout.sv
// vram_scanout: VGA scan-out of a 320x200x4bpp frame buffer, pixel/line doubled into a bordered 640x480 raster
module vram_scanout #(
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int WIN_TOP = 40
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic [14:0] o_vram_addr,
  input  logic [7:0]  i_vram_data,
  input  logic [3:0]  i_border,
  output logic [3:0]  o_pixel,
  output logic        o_hsync_n,
  output logic        o_vsync_n,
  output logic        o_blank,
  output logic        o_frame_irq
);
  localparam logic [9:0]  H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  H_END   = 10'(H_VIS);
  localparam logic [9:0]  V_END   = 10'(V_VIS);
  localparam logic [9:0]  HS_BEG  = 10'(H_VIS + H_FP);
  localparam logic [9:0]  HS_END  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0]  VS_BEG  = 10'(V_VIS + V_FP);
  localparam logic [9:0]  VS_END  = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [9:0]  W_BEG   = 10'(WIN_TOP);
  localparam logic [9:0]  W_END   = 10'(V_VIS - WIN_TOP - 1);
  localparam logic [9:0]  W_PRE   = 10'(WIN_TOP - 1);
  localparam logic [14:0] BPR     = 15'(H_VIS / 4);
  // pipeline word: {blank, hsync_n, vsync_n, in_window, border}
  localparam logic [7:0]  PIPE_RST = 8'hE0;
  logic [9:0]  r_hc;
  logic [9:0]  r_vc;
  logic [14:0] r_base;
  logic [14:0] r_addr;
  logic [7:0]  r_shift;
  logic [7:0]  r_pipe [3];
  logic [3:0]  r_pixel;
  logic        r_hs_n;
  logic        r_vs_n;
  logic        r_blank;
  logic        w_eol;
  logic        w_win;
  logic        w_vis;
  logic        w_fetch;
  logic        w_odd;
  logic        w_hs_n;
  logic        w_vs_n;
  logic [7:0]  w_tap;
  always_comb begin
    w_eol   = r_hc == H_LAST;
    w_win   = r_vc >= W_BEG && r_vc <= W_END;
    w_vis   = r_hc < H_END && r_vc < V_END;
    w_fetch = w_win && r_hc < H_END && r_hc[1:0] == 2'b00;
    w_odd   = r_vc[0] != W_BEG[0];
    w_hs_n  = !(r_hc >= HS_BEG && r_hc <= HS_END);
    w_vs_n  = !(r_vc >= VS_BEG && r_vc <= VS_END);
    w_tap   = r_pipe[2];
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hc <= '0;
      r_vc <= '0;
    end else begin
      r_hc <= w_eol ? '0 : r_hc + 10'd1;
      if (w_eol) r_vc <= (r_vc == V_LAST) ? '0 : r_vc + 10'd1;
    end
  end
  // each source row serves two screen lines; the base steps after the second
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_base <= '0;
      r_addr <= '0;
    end else begin
      if (w_eol && r_vc == W_PRE) r_base <= '0;
      else if (w_eol && w_win && w_odd) r_base <= r_base + BPR;
      if (w_fetch) r_addr <= (r_hc == '0) ? r_base : r_addr + 15'd1;
    end
  end
  // byte arrives two clocks after its address; high nibble first, then shifted up
  always_ff @(posedge i_clk) begin
    if (i_reset) r_shift <= '0;
    else if (r_hc[1:0] == 2'b10) r_shift <= i_vram_data;
    else if (r_hc[1:0] == 2'b00) r_shift <= {r_shift[3:0], 4'h0};
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 3; i++) r_pipe[i] <= PIPE_RST;
      r_pixel <= '0;
      r_blank <= 1'b1;
      r_hs_n  <= 1'b1;
      r_vs_n  <= 1'b1;
    end else begin
      r_pipe[0] <= {!w_vis, w_hs_n, w_vs_n, w_win, i_border};
      r_pipe[1] <= r_pipe[0];
      r_pipe[2] <= r_pipe[1];
      r_blank   <= w_tap[7];
      r_hs_n    <= w_tap[6];
      r_vs_n    <= w_tap[5];
      r_pixel   <= w_tap[7] ? 4'h0 : w_tap[4] ? r_shift[7:4] : w_tap[3:0];
    end
  end
  assign o_vram_addr = r_addr;
  assign o_pixel     = r_pixel;
  assign o_hsync_n   = r_hs_n;
  assign o_vsync_n   = r_vs_n;
  assign o_blank     = r_blank;
  assign o_frame_irq = r_hc == '0 && r_vc == V_END;
endmodule

// File: tb/tb_vram_scanout.sv
// tb_vram_scanout: directed checks of timing, fetch addresses, pixel order, border and reset
module tb_vram_scanout;
  localparam int H  = 800;
  localparam int FR = 27 * H;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] vram_addr;
  logic [7:0]  vram_data = 8'h00;
  logic [3:0]  border = 4'h7;
  logic [3:0]  pixel;
  logic        hsync_n, vsync_n, blank, frame_irq;
  logic [7:0]  mem [32768];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          hs_lo = 0, vs_lo = 0, irqs = 0, max_addr = 0;
  bit          cnt_en = 1'b0;
  int          pix_tab [8] = '{10, 10, 5, 5, 3, 3, 12, 12};
  int          wrap_tab [4] = '{5, 5, 12, 12};

  vram_scanout #(.V_VIS(20), .V_FP(2), .V_SYNC(2), .V_BP(3), .WIN_TOP(4)) dut (
    .i_clk(clk), .i_reset(reset), .o_vram_addr(vram_addr), .i_vram_data(vram_data),
    .i_border(border), .o_pixel(pixel), .o_hsync_n(hsync_n), .o_vsync_n(vsync_n),
    .o_blank(blank), .o_frame_irq(frame_irq)
  );

  always #20 clk = ~clk;

  function automatic logic [7:0] exp_byte(input int a);
    return a == 0 ? 8'hA5 : a == 1 ? 8'h3C : 8'((a * 7 + 3) & 255);
  endfunction

  always @(posedge clk) vram_data <= mem[vram_addr];
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  always @(negedge clk) begin
    if (cnt_en) begin
      if (!hsync_n) hs_lo++;
      if (!vsync_n) vs_lo++;
      if (frame_irq) irqs++;
    end
    if (!reset && int'(vram_addr) > max_addr) max_addr = int'(vram_addr);
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic goto(input int n);
    int g = 0;
    while (cyc != n && g < 200000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (cyc != n) begin
      check("goto_timeout", cyc, n);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pixel"}, int'(pixel), 0);
    check({tag, "_blank"}, int'(blank), 1);
    check({tag, "_hsync"}, int'(hsync_n), 1);
    check({tag, "_vsync"}, int'(vsync_n), 1);
    check({tag, "_addr"}, int'(vram_addr), 0);
    check({tag, "_irq"}, int'(frame_irq), 0);
  endtask

  initial begin
    for (int a = 0; a < 32768; a++) mem[a] = exp_byte(a);
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset = 1'b0;
    cnt_en = 1'b1;
    goto(3);       check("pipe_blank", int'(blank), 1);
    goto(4);       check("first_blank", int'(blank), 0);
                   check("first_border", int'(pixel), 7);
    goto(643);     check("last_vis_blank", int'(blank), 0);
    goto(644);     check("hblank", int'(blank), 1);
                   check("hblank_pix", int'(pixel), 0);
    goto(659);     check("hs_pre", int'(hsync_n), 1);
    goto(660);     check("hs_fall", int'(hsync_n), 0);
    goto(755);     check("hs_last", int'(hsync_n), 0);
    goto(756);     check("hs_rise", int'(hsync_n), 1);
    goto(3*H+100); border = 4'h2;
    goto(3*H+103); check("bord_old", int'(pixel), 7);
    goto(3*H+104); check("bord_new", int'(pixel), 2);
                   border = 4'h7;
    goto(3*H+107); check("bord_hold", int'(pixel), 2);
    goto(3*H+108); check("bord_back", int'(pixel), 7);
    for (int n = 0; n < 644; n++) begin
      goto(4*H+n);
      if (n % 4 == 1 && n < 640) check("addr_l4", int'(vram_addr), n / 4);
      if (n >= 4 && n < 12) check("pix_order", int'(pixel), pix_tab[n-4]);
      if (n >= 640) check("pix_wrap", int'(pixel), wrap_tab[n-640]);
    end
    for (int k = 0; k < 160; k++) begin
      goto(5*H+4*k+1); check("addr_l5", int'(vram_addr), k);
    end
    for (int k = 0; k < 160; k++) begin
      goto(6*H+4*k+1); check("addr_l6", int'(vram_addr), 160 + k);
      goto(6*H+4*k+4); check("pix_l6", int'(pixel), int'(exp_byte(160 + k) >> 4));
    end
    for (int k = 0; k < 160; k++) begin
      goto(15*H+4*k+1); check("addr_l15", int'(vram_addr), 800 + k);
    end
    goto(16*H+14);  check("bord_below", int'(pixel), 7);
    goto(16*H+643); check("bord_below_end", int'(pixel), 7);
    goto(20*H);     check("irq_on", int'(frame_irq), 1);
    goto(20*H+1);   check("irq_off", int'(frame_irq), 0);
    goto(20*H+104); check("vblank", int'(blank), 1);
                    check("vblank_pix", int'(pixel), 0);
    goto(22*H+3);   check("vs_pre", int'(vsync_n), 1);
    goto(22*H+4);   check("vs_fall", int'(vsync_n), 0);
    goto(24*H+3);   check("vs_last", int'(vsync_n), 0);
    goto(24*H+4);   check("vs_rise", int'(vsync_n), 1);
    goto(FR+4*H+1); check("f2_addr0", int'(vram_addr), 0);
    goto(FR+4*H+4); check("f2_pix0", int'(pixel), 10);
    goto(FR+4*H+5); check("f2_addr1", int'(vram_addr), 1);
    goto(2*FR);
    cnt_en = 1'b0;
    check("hs_low_count", hs_lo, 54 * 96);
    check("vs_low_count", vs_lo, 2 * 2 * H);
    check("irq_count", irqs, 2);
    goto(2*FR+10*H+300);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("midreset");
    reset = 1'b0;
    goto(3);       check("mr_pipe_blank", int'(blank), 1);
    goto(4*H+1);   check("mr_addr0", int'(vram_addr), 0);
    goto(4*H+4);   check("mr_pix0", int'(pixel), 10);
    goto(4*H+5);   check("mr_addr1", int'(vram_addr), 1);
    goto(5*H+637); check("mr_addr159", int'(vram_addr), 159);
    check("max_addr", max_addr, 959);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vram_scanout.md
# vram_scanout

Video scan-out engine that drives VGA 640x480@60 timing from a single 25 MHz pixel clock. It reads the frame buffer through the video-side read-only port of the 32 KB dual-port video RAM and emits 4-bit palette indices with sync and blank. The bitmap is 320x200 pixels at 4 bpp, shown pixel- and line-doubled as 640x400, centred vertically inside a border band. It is the consumer at the far end of the CPU-writes / video-reads frame buffer path.

## Interface
- H_VIS, 640, visible clocks per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch (total 800)
- V_VIS, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches and sync (total 525)
- WIN_TOP, 40, first screen line of bitmap window (window = lines 40..439)
- BYTES_PER_ROW, 160, frame-buffer bytes per source row

- clk  in  1  pixel clock, 25 MHz; sole clock
- reset  in  1  synchronous, active-high
- vram_addr  out  15  byte address to VRAM read port, registered
- vram_data  in  8  VRAM read data, valid on the second rising edge after vram_addr changes (VRAM output register)
- border  in  4  palette index shown outside bitmap window inside visible area
- pixel  out  4  palette index, registered; 0 when blanked
- hsync_n  out  1  horizontal sync, active low
- vsync_n  out  1  vertical sync, active low
- blank  out  1  high outside visible 640x480
- frame_irq  out  1  one-clock pulse at start of vertical blank

## Operation
- Counters: hc 0..799 wraps to 0; vc advances when hc wraps, 0..524, wraps to 0. Visible area: hc<640 && vc<480.
- Window: vc in [40,439]. Source row r = (vc-40)>>1, so each row is fetched on two consecutive lines. Byte k of a line (k = 0..159) covers screen columns 4k..4k+3.
- Address: vram_addr = r*160 + k, computed incrementally (no multiplier). Row base register advances by 160 after each odd window line. Row base resets to 0 at vc=40. Maximum address 31999; upper region 32000..32767 is never read.
- Fetch: at hc=4k (k = 0..159, window line), register vram_addr for byte k. The data returned is loaded into the pixel shift register at hc=4k+3. Pixel order: high nibble on columns 4k and 4k+1, low nibble on columns 4k+2 and 4k+3.
- Outside the window or at hc ≥ 640, vram_addr holds its last value (no wrap beyond 31999).
- Output mux per column: blanked → 0; outside window → border; else shifted nibble.
- Sync generation: hsync_n low for hc in [656,751]; vsync_n low for vc in [490,491].
- frame_irq: high for exactly one clock when hc=0 && vc=480, undelayed relative to the counters.
- Reset state: hc=0, vc=0, row base=0, vram_addr=0, shift register=0, pixel=0, hsync_n=1, vsync_n=1, blank=1, frame_irq=0.
- Reset mid-frame: all state returns to the reset values on the next edge. The first line after reset starts a fresh frame at vc=0. No partial pixel is emitted.

## Timing
- Fixed output latency of 4 clocks. pixel, blank, hsync_n and vsync_n for counter position (hc, vc) all appear 4 cycles later, mutually aligned. Sync/blank are pipelined through the same 4-stage delay so they stay aligned with the pixels.
- The value registered at hc=4k appears on vram_addr from hc=4k+1. VRAM data is usable at hc=4k+2 and captured at hc=4k+3. The first pixel of byte k is output at the edge corresponding to hc=4k+4.
- Line wrap: the delay pipeline carries the last visible pixels of hc 636..639 across into hc 640..643. The fetch for byte 0 of the next line occurs at hc=0 of that line.
- border changes take effect on the pixel output 4 clocks after sampling, with no glitch.

## Test plan
- Reset: hold reset 3 clocks, release → pixel=0, blank=1, hsync_n=1, vsync_n=1, vram_addr=0, frame_irq=0. The first hsync_n fall occurs 656+4 clocks after release.
- Sync counts: run 2 frames → hsync_n low for 96 clocks every 800; vsync_n low for 1600 clocks every 420000; frame_irq pulses exactly once per frame, at hc=0, vc=480.
- Address sequence: monitor vram_addr on lines 40 and 41 → 0,1,...,159 each line. Line 42 → 160..319. Line 439 → 31840..31999. No address above 31999 ever appears.
- Pixel order: VRAM model returns 0xA5 at addr 0 and 0x3C at addr 1 → line 40, columns 0..7 = A,A,5,5,3,3,C,C, output 4 clocks after the corresponding hc.
- Border: border=0x7 → line 39 and line 440 visible columns all 7. Blanked region (hc ≥ 640 delayed, or vc ≥ 480) → pixel=0, blank=1.
- Reset mid-line: assert reset at vc=100, hc=300 for 1 clock → next edge matches the reset state. A full new frame follows with the correct addresses starting at 0 on line 40.
